instr_fetch_unit: RTL and testbench

Sequences the instruction ROM for the single-issue LEGv8 core. Owns the fetch PC (word-indexed, matches the ROM's 16-bit address) and drives the ROM address. Buffers fetched words in a 2-entry queue toward decode with a valid/ready handshake. Accepts PC redirects from execute (CBZ/B/BR) and stops fetching on the halt word (BR XZR).

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 55 +++++
 rtl/instr_fetch_unit.sv | 72 +++++++
 tb/tb_instr_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

    localparam int                    DEF_ADDR_W    = 16;
    localparam int                    DEF_DEPTH     = 2;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC  = 16'h0000;
    localparam logic [31:0]           DEF_HALT_WORD = 32'hD60003E0;   // BR XZR

    // Fetch state machine encoding.
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t ST_FETCH = 1'b0;
    localparam fetch_state_t ST_HALT  = 1'b1;

    // One fetched instruction together with the word address it came from.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between the ROM and decode. Flush empties it and
// overrides push/pop; push and pop in the same cycle are legal even when full.
module fetch_queue #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pop only a real entry; push only with room (or room being freed this cycle).
    assign do_pop  = pop && (count != '0) && !flush;
    assign do_push = push && !flush && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    // NOTE: storage has no reset; count alone decides validity, so stale words are never exposed.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC, halt state machine and redirect handling for the LEGv8 core.
// Words are read combinationally from the ROM and buffered toward decode.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DEPTH     = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
    parameter logic [31:0]       HALT_WORD = DEF_HALT_WORD
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [31:0]       rom_data,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    input  logic              if_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]    fetch_pc;
    fetch_state_t         state;
    logic [CNT_W-1:0]     count;
    logic [ADDR_W+31:0]   head;
    logic                 push;
    logic                 pop;

    assign rom_address = fetch_pc;
    assign if_valid    = (count != '0);
    assign pop         = if_valid && if_ready;
    assign push        = (state == ST_FETCH) && !redirect_valid
                         && ((count < CNT_W'(DEPTH)) || pop);
    assign halted      = (state == ST_HALT) && (count == '0);

    // Head fields are forced to zero while the queue is empty.
    assign if_pc    = if_valid ? head[ADDR_W+31:32] : '0;
    assign if_instr = if_valid ? head[31:0]         : '0;

    fetch_queue #(
        .WIDTH (ADDR_W + 32),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wdata   ({fetch_pc, rom_data}),
        .head    (head),
        .count   (count)
    );

    // Fetch PC and FETCH/HALT state: reset, then redirect, then sequential advance.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            state    <= ST_FETCH;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            state    <= ST_FETCH;
        end else if (push) begin
            fetch_pc <= fetch_pc + 1'b1;          // wraps modulo 2^ADDR_W
            if (rom_data == HALT_WORD) state <= ST_HALT;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: a stream-level reference model fills a scoreboard of
// expected {pc, instr} words; a monitor compares every presented head word.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] HALT_W = 32'hD60003E0;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] rom_address;
    logic [31:0] rom_data;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    fetch_entry_t sb[$];
    logic         halt_done = 1'b0;

    always #5 clock = ~clock;

    instr_fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rom_address    (rom_address),
        .rom_data       (rom_data),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    // Copy-loop program at 0..10 (halt at 10); everything else is a plain ADD-like word.
    function automatic logic [31:0] rom_word(input logic [15:0] a);
        case (a)
            16'd0:   return 32'h910193E4;
            16'd1:   return 32'hF9400085;
            16'd2:   return 32'hF9000086;
            16'd3:   return 32'h91002084;
            16'd4:   return 32'h910020C6;
            16'd5:   return 32'hD10004A5;
            16'd6:   return 32'hB5FFFF65;
            16'd7:   return 32'hAA0403E0;
            16'd8:   return 32'h8B010000;
            16'd9:   return 32'hD503201F;
            16'd10:  return HALT_W;
            default: return 32'h8B000000 | {16'h0000, a};
        endcase
    endfunction

    assign rom_data = rom_word(rom_address);

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: after (re)start at 'start' the core sees consecutive
    // words up to and including the first halt word.
    task automatic fill_stream(input logic [15:0] start);
        logic [15:0]  a;
        fetch_entry_t e;
        sb.delete();
        halt_done = 1'b0;
        a = start;
        for (int i = 0; i < 256; i++) begin
            e.pc    = a;
            e.instr = rom_word(a);
            sb.push_back(e);
            if (e.instr == HALT_W) break;
            a = a + 16'd1;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_redirect(input logic [15:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        fill_stream(target);
        step();
        redirect_valid = 1'b0;
        check("redir_bubble_valid", 48'(if_valid), 48'(1'b0));
    endtask

    // Monitor: compares head against the scoreboard, checks stall stability and halted.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;
    always @(negedge clock) begin
        fetch_entry_t exp;
        if (!reset_n || redirect_valid) begin
            prev_stall = 1'b0;
        end else begin
            check("halted", 48'(halted), 48'(halt_done));
            if (prev_stall) begin
                check("stall_valid", 48'(if_valid), 48'(1'b1));
                check("stall_pc", 48'(if_pc), 48'(prev_pc));
                check("stall_instr", 48'(if_instr), 48'(prev_instr));
            end
            if (sb.size() == 0) begin
                check("spurious_valid", 48'(if_valid), 48'(1'b0));
            end else if (if_valid) begin
                exp = sb[0];
                check("head_pc", 48'(if_pc), 48'(exp.pc));
                check("head_instr", 48'(if_instr), 48'(exp.instr));
                if (if_ready) begin
                    exp = sb.pop_front();
                    if (exp.instr == HALT_W) halt_done = 1'b1;
                end
            end
            prev_stall = if_valid && !if_ready;
            prev_pc    = if_pc;
            prev_instr = if_instr;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          since;
        int          r;
        logic [15:0] t;

        // Reset state and streaming with if_ready held high.
        if_ready = 1'b1;
        fill_stream(16'h0000);
        step();
        step();
        check("rst_valid", 48'(if_valid), 48'(1'b0));
        check("rst_instr", 48'(if_instr), 48'(0));
        check("rst_pc", 48'(if_pc), 48'(0));
        check("rst_rom_addr", 48'(rom_address), 48'(0));
        check("rst_halted", 48'(halted), 48'(1'b0));
        reset_n = 1'b1;
        step();
        check("first_valid", 48'(if_valid), 48'(1'b1));
        check("first_pc", 48'(if_pc), 48'(0));
        check("first_instr", 48'(if_instr), 48'(32'h910193E4));
        for (int k = 1; k <= 4; k++) begin
            step();
            check("stream_valid", 48'(if_valid), 48'(1'b1));
            check("stream_pc", 48'(if_pc), 48'(k));
        end

        // Backpressure right after the first valid word.
        reset_n  = 1'b0;
        if_ready = 1'b0;
        fill_stream(16'h0000);
        step();
        reset_n = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_pc", 48'(if_pc), 48'(0));
            step();
        end
        check("bp_rom_addr", 48'(rom_address), 48'(2));
        if_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("bp_release_pc", 48'(if_pc), 48'(k));
        end

        // Redirect while the queue holds pcs 5 and 6 (a pop in the redirect cycle is ignored).
        if_ready = 1'b0;
        do_redirect(16'd5);
        step();
        step();
        check("q56_head", 48'(if_pc), 48'(5));
        if_ready = 1'b1;
        do_redirect(16'd3);
        step();
        check("redir_pc3", 48'(if_pc), 48'(3));
        step();
        check("redir_pc4", 48'(if_pc), 48'(4));

        // Run into the halt word at address 10, then leave HALT with a redirect.
        do_redirect(16'd7);
        for (int i = 0; i < 30 && !halted; i++) step();
        check("halt_reached", 48'(halted), 48'(1'b1));
        check("halt_rom_addr", 48'(rom_address), 48'(11));
        check("halt_no_valid", 48'(if_valid), 48'(1'b0));
        do_redirect(16'd0);
        check("unhalt", 48'(halted), 48'(1'b0));
        step();
        check("resume_pc", 48'(if_pc), 48'(0));
        check("resume_valid", 48'(if_valid), 48'(1'b1));

        // Address wrap.
        do_redirect(16'hFFFF);
        step();
        check("wrap_ffff", 48'(if_pc), 48'(16'hFFFF));
        step();
        check("wrap_0000", 48'(if_pc), 48'(16'h0000));
        step();
        check("wrap_0001", 48'(if_pc), 48'(16'h0001));

        // Reset while the queue is full and stalled.
        if_ready = 1'b0;
        step();
        step();
        step();
        reset_n = 1'b0;
        fill_stream(16'h0000);
        step();
        check("midrst_valid", 48'(if_valid), 48'(1'b0));
        check("midrst_rom_addr", 48'(rom_address), 48'(0));
        check("midrst_halted", 48'(halted), 48'(1'b0));
        reset_n  = 1'b1;
        if_ready = 1'b1;
        step();
        check("midrst_first_pc", 48'(if_pc), 48'(0));
        check("midrst_first_valid", 48'(if_valid), 48'(1'b1));

        // Randomized traffic: backpressure, redirects, occasional resets.
        since = 0;
        for (int c = 0; c < 3000; c++) begin
            reset_n        = 1'b1;
            redirect_valid = 1'b0;
            if_ready       = ($urandom_range(0, 3) != 0);
            r              = int'($urandom_range(0, 299));
            if (r == 0) begin
                reset_n = 1'b0;
                fill_stream(16'h0000);
                since = 0;
            end else if (r < 8 || since > 150 || (halted && r < 60)) begin
                case ($urandom_range(0, 2))
                    0:       t = 16'($urandom_range(0, 12));
                    1:       t = 16'($urandom);
                    default: t = 16'hFFF0 | 16'($urandom_range(0, 15));
                endcase
                redirect_valid = 1'b1;
                redirect_pc    = t;
                fill_stream(t);
                since = 0;
            end
            step();
            since++;
        end

        reset_n        = 1'b1;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        for (int k = 0; k < 5; k++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
